// File: rtl/ext_pipe_pkg.sv
// Shared types and defaults for the operand extender pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ext_mode_t mode encoding (ZERO/SIGN/UPPER/BIT), default field widths.
package ext_pipe_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 32;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,  // {zeros, field}
        SIGN  = 2'b01,  // {sign bits, field}
        UPPER = 2'b10,  // field in the top bits, zeros below (LUI style)
        BIT   = 2'b11   // {zeros, field[0]} for SLT/flag results
    } ext_mode_t;

endpackage

// File: rtl/ext_pipe_core.sv
// Purely combinational IN_W -> OUT_W extender, shared with the branch-offset path.
// Latency: 0 cycles (combinational).
// Backpressure: none; no state.
// Ports: in_data (IN_W field), in_mode (ext_mode_t) -> out_data (OUT_W result).
module ext_core
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [IN_W-1:0]  in_data,
    input  ext_mode_t        in_mode,
    output logic [OUT_W-1:0] out_data
);

    always_comb begin
        out_data = '0;
        case (in_mode)
            ZERO:    out_data = {{(OUT_W-IN_W){1'b0}}, in_data};
            SIGN:    out_data = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
            UPPER:   out_data = {in_data, {(OUT_W-IN_W){1'b0}}};
            BIT:     out_data = {{(OUT_W-1){1'b0}}, in_data[0]};
            default: out_data = '0;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate/flag extender between decode and the ALU operand mux.
// Latency: 1 cycle from input accept to out_valid; 1 item/cycle with out_ready high.
// Backpressure: main + skid register (2 items); in_ready = !skid_valid, no out_ready->in_ready path.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_mode upstream;
//        out_valid/out_ready/out_data downstream; xfer_cnt (saturating accept count)
//        exists only when the EXT_STATS_EN macro is defined.
module ext_pipe
    import ext_pipe_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef EXT_STATS_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    if (IN_W < 1 || IN_W >= OUT_W) begin : g_bad_width
        $error("ext_pipe: IN_W must satisfy 1 <= IN_W < OUT_W");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("ext_pipe: CNT_W must be at least 1");
    end

    logic [OUT_W-1:0] ext_res;
    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic             accept;
    logic             main_free;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_data  (in_data),
        .in_mode  (ext_mode_t'(in_mode)),
        .out_data (ext_res)
    );

    // Skid only fills while main is stalled, so an empty skid always has room.
    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    // Main can take a new item when it is empty or being consumed this cycle.
    assign main_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (main_free) begin
            // Skid holds the older item, so it refills main ahead of any new input
            // (an accept cannot coincide with a full skid anyway).
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= ext_res;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Main stalled: park the new item so out_data stays stable.
            skid_data  <= ext_res;
            skid_valid <= 1'b1;
        end
    end

`ifdef EXT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (accept && (xfer_cnt != {CNT_W{1'b1}})) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Testbench for ext_pipe: scoreboard + random traffic, wide (16->32) and narrow (1->32) instances.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Wide instance, IN_W=16, OUT_W=32, CNT_W=4
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;

    // Narrow instance, IN_W=1, OUT_W=32
    logic        n_valid = 1'b0;
    logic        n_ready;
    logic        n_data = 1'b0;
    logic [1:0]  n_mode = '0;
    logic        n_ovalid;
    logic        n_oready = 1'b1;
    logic [31:0] n_odata;

`ifdef EXT_STATS_EN
    logic [3:0]  xfer_cnt;
    logic [15:0] n_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] q[$];
    logic [31:0] nq[$];
    int          mcnt  = 0;
    int          nmcnt = 0;

    always #5 clk = ~clk;

    ext_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef EXT_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    ext_pipe #(.IN_W(1), .OUT_W(32)) dut_n (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (n_valid),
        .in_ready  (n_ready),
        .in_data   (n_data),
        .in_mode   (n_mode),
        .out_valid (n_ovalid),
        .out_ready (n_oready),
        .out_data  (n_odata)
`ifdef EXT_STATS_EN
        ,
        .xfer_cnt  (n_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension from the arithmetic meaning of each mode.
    function automatic logic [31:0] ref_ext(input longint d, input int w, input logic [1:0] m);
        longint r;
        longint half;
        half = longint'(1) << (w - 1);
        case (m)
            2'd0:    r = d;
            2'd1:    r = (d >= half) ? d + ((longint'(1) << 32) - (longint'(1) << w)) : d;
            2'd2:    r = d * (longint'(1) << (32 - w));
            default: r = d % 2;
        endcase
        return r[31:0];
    endfunction

    // Monitor/scoreboard for the wide instance. Occupancy < 2 means room in the stage.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            check("in_ready", in_ready, q.size() < 2);
            check("out_valid", out_valid, q.size() > 0);
`ifdef EXT_STATS_EN
            check("xfer_cnt", xfer_cnt, mcnt);
`endif
            if (out_valid && q.size() > 0) begin
                check("out_data", out_data, q[0]);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_ext(longint'(in_data), 16, in_mode));
                if (mcnt < 15) mcnt++;
            end
        end
    end

    // Monitor/scoreboard for the narrow instance.
    always @(negedge clk) begin
        if (rst) begin
            nq.delete();
            nmcnt = 0;
        end else begin
            check("n_in_ready", n_ready, nq.size() < 2);
            check("n_out_valid", n_ovalid, nq.size() > 0);
`ifdef EXT_STATS_EN
            check("n_xfer_cnt", n_cnt, nmcnt);
`endif
            if (n_ovalid && nq.size() > 0) begin
                check("n_out_data", n_odata, nq[0]);
                if (n_oready) void'(nq.pop_front());
            end
            if (n_valid && n_ready) begin
                nq.push_back(ref_ext(longint'(n_data), 1, n_mode));
                nmcnt++;
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] m);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        check("send_accepted", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic nsend(input logic d, input logic [1:0] m);
        logic acc;
        acc     = 1'b0;
        n_valid = 1'b1;
        n_data  = d;
        n_mode  = m;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = n_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        check("nsend_accepted", acc, 1);
        n_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc_last;
        acc_last = 1'b0;

        // Reset; in_valid offered during reset must be ignored.
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // All four modes on 16'h8001, back to back with out_ready high.
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) send(16'h8001, m[1:0]);
        idle(3);

        // Back-to-back A, B, C.
        send(16'h7fff, 2'd1);
        send(16'h00a5, 2'd2);
        send(16'hfffe, 2'd3);
        idle(3);

        // Stall with three items offered, then release.
        out_ready = 1'b0;
        fork
            begin
                send(16'h1111, 2'd0);
                send(16'h8222, 2'd1);
                send(16'h3333, 2'd2);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);

        // Random traffic with random downstream stalls; offers held until taken.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || acc_last) begin
                in_valid = $urandom_range(0, 1);
                in_data  = 16'($urandom);
                in_mode  = 2'($urandom);
            end
            @(negedge clk);
            acc_last = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // Reset with two items buffered: both must vanish.
        out_ready = 1'b0;
        send(16'hdead, 2'd0);
        send(16'hbeef, 2'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 32'h0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(5);

        // 20 accepted items to drive the counter into saturation.
        for (int i = 0; i < 20; i++) send(16'($urandom), 2'($urandom));
        idle(3);

        // Narrow instance: all modes on 1'b1 and 1'b0.
        for (int m = 0; m < 4; m++) nsend(1'b1, m[1:0]);
        for (int m = 0; m < 4; m++) nsend(1'b0, m[1:0]);
        idle(4);

        // Final reset clears the counter (monitor checks xfer_cnt against 0).
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
